mshr_miss_dispatch: RTL and testbench

Sits directly downstream of the MSHR read port. It consumes un-issued miss entries in MSHR order, issues each one as a request to the lower memory level with a valid/ready handshake, and advances the MSHR read pointer. When a memory response returns, it produces a fill to the cache and retires the matching MSHR entry through the MSHR delete port. It tracks the count of outstanding requests and throttles issue at a configurable limit.

---
 rtl/mshr_miss_dispatch.sv | 111 +++++++++++
 tb/tb_mshr_miss_dispatch.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mshr_miss_dispatch.sv
// Miss dispatcher between the MSHR read port and the lower memory level.
// Issues misses in MSHR order, throttles on outstanding count, and turns responses into fills/retires.
module mshr_miss_dispatch #(
  parameter int addr_tag_bits   = 20,
  parameter int data_bits       = 90,
  parameter int line_bits       = 128,
  parameter int max_outstanding = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     mshr_read_valid,
  input  logic [addr_tag_bits-1:0] mshr_read_addr_tag,
  input  logic [data_bits-1:0]     mshr_read_addr_data,
  output logic                     mshr_read_next,
  output logic                     mshr_del,
  output logic [addr_tag_bits-1:0] mshr_del_addr_tag,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [addr_tag_bits-1:0] mem_req_addr_tag,
  output logic [data_bits-1:0]     mem_req_data,
  input  logic                     mem_resp_valid,
  output logic                     mem_resp_ready,
  input  logic [addr_tag_bits-1:0] mem_resp_addr_tag,
  input  logic [line_bits-1:0]     mem_resp_data,
  output logic                     fill_valid,
  output logic [addr_tag_bits-1:0] fill_addr_tag,
  output logic [line_bits-1:0]     fill_data,
  output logic [3:0]               outstanding,
  output logic                     err_spurious_resp
);

  typedef enum logic [1:0] {IDLE, ISSUE, ADVANCE, SETTLE} state_t;

  localparam logic [3:0] max_out = 4'(max_outstanding);

  state_t state;
  logic   read_next_q;
  logic   del_q;
  logic   fill_q;
  logic   req_accept;
  logic   resp_fire;
  logic   resp_good;

  assign mem_resp_ready = enable & ~reset;
  assign resp_fire      = mem_resp_valid & mem_resp_ready;
  assign resp_good      = resp_fire & (outstanding != 4'd0);
  assign req_accept     = enable & (state == ISSUE) & mem_req_valid & mem_req_ready;

  // Pulse registers hold across a stall so no event is lost; only their visibility is gated.
  assign mshr_read_next = read_next_q & enable;
  assign mshr_del       = del_q & enable;
  assign fill_valid     = fill_q & enable;

  // NOTE: every register here, including the tag/data holding registers, uses <= and is reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      mem_req_valid    <= 1'b0;
      mem_req_addr_tag <= '0;
      mem_req_data     <= '0;
      read_next_q      <= 1'b0;
      outstanding      <= 4'd0;
    end else if (enable) begin
      read_next_q <= 1'b0;
      case (state)
        IDLE: begin
          if (mshr_read_valid && (outstanding < max_out)) begin
            mem_req_addr_tag <= mshr_read_addr_tag;
            mem_req_data     <= mshr_read_addr_data;
            mem_req_valid    <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            read_next_q   <= 1'b1;
            state         <= ADVANCE;
          end
        end
        ADVANCE: state <= SETTLE;
        SETTLE:  state <= IDLE;
        default: state <= IDLE;
      endcase
      outstanding <= outstanding + {3'b000, req_accept} - {3'b000, resp_good};
    end
  end

  // Response path runs beside the FSM; tags are forwarded verbatim, so out-of-order returns are fine.
  always_ff @(posedge clk) begin
    if (reset) begin
      del_q             <= 1'b0;
      fill_q            <= 1'b0;
      mshr_del_addr_tag <= '0;
      fill_addr_tag     <= '0;
      fill_data         <= '0;
      err_spurious_resp <= 1'b0;
    end else if (enable) begin
      del_q  <= resp_good;
      fill_q <= resp_good;
      if (resp_good) begin
        mshr_del_addr_tag <= mem_resp_addr_tag;
        fill_addr_tag     <= mem_resp_addr_tag;
        fill_data         <= mem_resp_data;
      end
      if (resp_fire && (outstanding == 4'd0)) err_spurious_resp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mshr_miss_dispatch.sv
// Self-checking bench for mshr_miss_dispatch: transaction-level model plus directed scenarios.
module tb_mshr_miss_dispatch;
  localparam int AT  = 20;
  localparam int DB  = 90;
  localparam int LB  = 128;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          mshr_read_valid;
  logic [AT-1:0] mshr_read_addr_tag;
  logic [DB-1:0] mshr_read_addr_data;
  logic          mshr_read_next;
  logic          mshr_del;
  logic [AT-1:0] mshr_del_addr_tag;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AT-1:0] mem_req_addr_tag;
  logic [DB-1:0] mem_req_data;
  logic          mem_resp_valid;
  logic          mem_resp_ready;
  logic [AT-1:0] mem_resp_addr_tag;
  logic [LB-1:0] mem_resp_data;
  logic          fill_valid;
  logic [AT-1:0] fill_addr_tag;
  logic [LB-1:0] fill_data;
  logic [3:0]    outstanding;
  logic          err_spurious_resp;

  always #5 clk = ~clk;

  mshr_miss_dispatch #(
    .addr_tag_bits(AT), .data_bits(DB), .line_bits(LB), .max_outstanding(MAX)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .mshr_read_valid(mshr_read_valid), .mshr_read_addr_tag(mshr_read_addr_tag),
    .mshr_read_addr_data(mshr_read_addr_data), .mshr_read_next(mshr_read_next),
    .mshr_del(mshr_del), .mshr_del_addr_tag(mshr_del_addr_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr_tag(mem_req_addr_tag), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_addr_tag(mem_resp_addr_tag), .mem_resp_data(mem_resp_data),
    .fill_valid(fill_valid), .fill_addr_tag(fill_addr_tag), .fill_data(fill_data),
    .outstanding(outstanding), .err_spurious_resp(err_spurious_resp)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: in-flight count = accepted requests minus honoured responses.
  int            m_out  = 0;
  int            n_acc  = 0;
  bit            m_err  = 1'b0;
  bit            m_del  = 1'b0;
  bit            m_rn   = 1'b0;
  logic [AT-1:0] m_tag  = '0;
  logic [LB-1:0] m_line = '0;
  // Values seen at the previous edge, for request-channel protocol checks.
  bit            p_valid = 1'b0, p_acc = 1'b0, p_rst = 1'b1, p_launch = 1'b0;
  logic [AT-1:0] p_head_tag = '0, p_req_tag = '0;
  logic [DB-1:0] p_head_data = '0, p_req_data = '0;
  bit            chk_en = 1'b0;

  always @(posedge clk) begin
    p_valid     <= (mem_req_valid === 1'b1);
    p_rst       <= reset;
    p_acc       <= !reset && enable && mem_req_valid && mem_req_ready;
    p_launch    <= !reset && enable && mshr_read_valid && (m_out < MAX);
    p_head_tag  <= mshr_read_addr_tag;
    p_head_data <= mshr_read_addr_data;
    p_req_tag   <= mem_req_addr_tag;
    p_req_data  <= mem_req_data;
    if (reset) begin
      m_out <= 0;
      m_err <= 1'b0;
      m_del <= 1'b0;
      m_rn  <= 1'b0;
    end else if (enable) begin
      m_rn  <= mem_req_valid && mem_req_ready;
      m_del <= mem_resp_valid && (m_out > 0);
      if (mem_resp_valid && (m_out > 0)) begin
        m_tag  <= mem_resp_addr_tag;
        m_line <= mem_resp_data;
      end
      if (mem_resp_valid && (m_out == 0)) m_err <= 1'b1;
      m_out <= m_out + int'(mem_req_valid && mem_req_ready) - int'(mem_resp_valid && (m_out > 0));
      if (mem_req_valid && mem_req_ready) n_acc <= n_acc + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("outstanding", 128'(outstanding), 128'(m_out));
      check("err_spurious", 128'(err_spurious_resp), 128'(m_err));
      check("resp_ready", 128'(mem_resp_ready), 128'(enable & ~reset));
      check("read_next", 128'(mshr_read_next), 128'(m_rn & enable));
      check("mshr_del", 128'(mshr_del), 128'(m_del & enable));
      check("fill_valid", 128'(fill_valid), 128'(m_del & enable));
      if (m_del && enable) begin
        check("del_tag", 128'(mshr_del_addr_tag), 128'(m_tag));
        check("fill_tag", 128'(fill_addr_tag), 128'(m_tag));
        check("fill_data", 128'(fill_data), 128'(m_line));
      end
      if (p_rst) check("req_valid_after_reset", 128'(mem_req_valid), 128'(0));
      if (p_valid && !p_acc && !p_rst) begin
        check("req_hold_valid", 128'(mem_req_valid), 128'(1));
        check("req_hold_tag", 128'(mem_req_addr_tag), 128'(p_req_tag));
        check("req_hold_data", 128'(mem_req_data), 128'(p_req_data));
      end
      if (!p_rst && !p_valid && (mem_req_valid === 1'b1)) begin
        check("launch_allowed", 128'(p_launch), 128'(1));
        check("launch_tag", 128'(mem_req_addr_tag), 128'(p_head_tag));
        check("launch_data", 128'(mem_req_data), 128'(p_head_data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input logic [AT-1:0] tag, input logic [LB-1:0] line);
    mem_resp_valid    = 1'b1;
    mem_resp_addr_tag = tag;
    mem_resp_data     = line;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    reset = 1'b1; enable = 1'b1;
    mshr_read_valid = 1'b0; mshr_read_addr_tag = '0; mshr_read_addr_data = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_addr_tag = '0; mem_resp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_outstanding", 128'(outstanding), 128'(0));
    check("rst_req_valid", 128'(mem_req_valid), 128'(0));
    check("rst_req_tag", 128'(mem_req_addr_tag), 128'(0));
    check("rst_fill_data", 128'(fill_data), 128'(0));
    reset = 1'b0;

    // Single miss
    mshr_read_valid = 1'b1; mshr_read_addr_tag = 20'h0ABCD;
    mshr_read_addr_data = 90'hDEAD_BEEF_CAFE; mem_req_ready = 1'b1;
    tick();
    mshr_read_valid = 1'b0;
    check("t1_req_valid", 128'(mem_req_valid), 128'(1));
    check("t1_req_tag", 128'(mem_req_addr_tag), 128'h0ABCD);
    check("t1_req_data", 128'(mem_req_data), 128'hDEAD_BEEF_CAFE);
    tick();
    check("t1_read_next", 128'(mshr_read_next), 128'(1));
    check("t1_outstanding", 128'(outstanding), 128'(1));
    check("t1_model_out", 128'(m_out), 128'(1));
    check("t1_req_dropped", 128'(mem_req_valid), 128'(0));
    tick();
    check("t1_read_next_end", 128'(mshr_read_next), 128'(0));
    resp(20'h0ABCD, {4{32'h5A5A_5A5A}});
    check("t1_del", 128'(mshr_del), 128'(1));
    check("t1_del_tag", 128'(mshr_del_addr_tag), 128'h0ABCD);
    check("t1_fill", 128'(fill_valid), 128'(1));
    check("t1_fill_data", 128'(fill_data), {4{32'h5A5A_5A5A}});
    check("t1_out_zero", 128'(outstanding), 128'(0));
    tick();
    check("t1_del_end", 128'(mshr_del), 128'(0));

    // Backpressure
    mem_req_ready = 1'b0; mshr_read_valid = 1'b1;
    mshr_read_addr_tag = 20'h12345; mshr_read_addr_data = 90'h1111_2222_3333;
    tick();
    mshr_read_valid = 1'b0;
    mshr_read_addr_tag = 20'hFFFFF;
    check("t2_req_valid", 128'(mem_req_valid), 128'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_tag", 128'(mem_req_addr_tag), 128'h12345);
      check("t2_no_read_next", 128'(mshr_read_next), 128'(0));
    end
    a0 = n_acc;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("t2_outstanding", 128'(outstanding), 128'(1));
    tick(); tick();
    check("t2_one_accept", 128'(n_acc - a0), 128'(1));
    check("t2_req_idle", 128'(mem_req_valid), 128'(0));
    resp(20'h12345, 128'h77);

    // Throttle at max_outstanding
    a0 = n_acc;
    mshr_read_valid = 1'b1; mshr_read_addr_tag = 20'h30000; mem_req_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (mshr_read_next) mshr_read_addr_tag = mshr_read_addr_tag + 20'd1;
    end
    check("t3_four_accepts", 128'(n_acc - a0), 128'(4));
    check("t3_outstanding", 128'(outstanding), 128'(4));
    check("t3_no_req", 128'(mem_req_valid), 128'(0));
    resp(20'h30002, 128'hABCD);
    check("t3_after_resp", 128'(outstanding), 128'(3));
    for (int i = 0; i < 10 && (n_acc - a0) < 5; i++) tick();
    mshr_read_valid = 1'b0; mem_req_ready = 1'b0;
    check("t3_fifth_accept", 128'(n_acc - a0), 128'(5));
    check("t3_out_full", 128'(outstanding), 128'(4));

    // Accept and response on the same edge
    resp(20'h30000, 128'h1);
    resp(20'h30001, 128'h2);
    check("t4_pre_out", 128'(outstanding), 128'(2));
    mshr_read_valid = 1'b1; mshr_read_addr_tag = 20'h44444;
    tick();
    mshr_read_valid = 1'b0;
    check("t4_req_valid", 128'(mem_req_valid), 128'(1));
    mem_req_ready = 1'b1;
    resp(20'h30003, 128'h3);
    mem_req_ready = 1'b0;
    check("t4_outstanding", 128'(outstanding), 128'(2));
    check("t4_del", 128'(mshr_del), 128'(1));
    check("t4_read_next", 128'(mshr_read_next), 128'(1));
    resp(20'h30004, 128'h4);
    resp(20'h44444, 128'h5);
    check("t4_drained", 128'(outstanding), 128'(0));

    // Spurious response
    resp(20'h55555, 128'h6);
    check("t5_no_del", 128'(mshr_del), 128'(0));
    check("t5_no_fill", 128'(fill_valid), 128'(0));
    check("t5_err", 128'(err_spurious_resp), 128'(1));
    repeat (3) tick();
    check("t5_err_sticky", 128'(err_spurious_resp), 128'(1));

    // Stall in ISSUE, then reset mid-ISSUE with three in flight
    a0 = n_acc;
    mshr_read_valid = 1'b1; mem_req_ready = 1'b1;
    for (int i = 0; i < 20 && (n_acc - a0) < 3; i++) tick();
    mshr_read_valid = 1'b0; mem_req_ready = 1'b0;
    check("t6_out3", 128'(outstanding), 128'(3));
    mshr_read_valid = 1'b1; mshr_read_addr_tag = 20'h66666;
    for (int i = 0; i < 10 && mem_req_valid !== 1'b1; i++) tick();
    mshr_read_valid = 1'b0;
    check("t6_in_issue", 128'(mem_req_valid), 128'(1));
    enable = 1'b0; mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    #1;
    check("t6_resp_ready_low", 128'(mem_resp_ready), 128'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_frozen_valid", 128'(mem_req_valid), 128'(1));
      check("t6_frozen_out", 128'(outstanding), 128'(3));
      check("t6_frozen_tag", 128'(mem_req_addr_tag), 128'h66666);
    end
    enable = 1'b1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_valid", 128'(mem_req_valid), 128'(0));
    check("t6_rst_out", 128'(outstanding), 128'(0));
    check("t6_rst_err", 128'(err_spurious_resp), 128'(0));
    mshr_read_valid = 1'b1; mshr_read_addr_tag = 20'h77777;
    tick();
    mshr_read_valid = 1'b0;
    check("t6_idle_launch", 128'(mem_req_valid), 128'(1));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
